// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants for the SRAM-to-AXI bridge: size codes, AXI IDs and FSM encodings.
package sram_axi_bridge_pkg;

  localparam logic [1:0] SIZE_W      = 2'd2;
  localparam logic [3:0] AXI_INST_ID = 4'd0;
  localparam logic [3:0] AXI_DATA_ID = 4'd1;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_AR     = 2'd1,
    RD_WAIT_R = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_AWW    = 2'd1,
    WR_WAIT_B = 2'd2
  } wr_state_e;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_rd_fsm.sv
// Per-port AXI read channel FSM (axi_read_channel_fsm): IDLE -> AR -> WAIT_R -> IDLE.
// Instanced once for instruction fetch and once for data loads.
module sram_axi_bridge_rd_fsm
  import sram_axi_bridge_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [3:0] ID     = 4'd0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic [3:0]        i_rid,
  output logic              o_arvalid,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [2:0]        o_arsize,
  output logic              o_data_ok,
  output rd_state_e         o_state
);

  rd_state_e         r_state;
  rd_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RD_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RD_IDLE && i_start) begin
        r_addr <= i_addr;
        r_size <= i_size;
      end
    end
  end

  // rready is tied high upstream, so any rvalid with our ID completes the read.
  always_comb begin
    w_next    = r_state;
    o_data_ok = 1'b0;
    case (r_state)
      RD_IDLE:   if (i_start) w_next = RD_AR;
      RD_AR:     if (i_arready) w_next = RD_WAIT_R;
      RD_WAIT_R: begin
        if (i_rvalid && (i_rid == ID)) begin
          o_data_ok = 1'b1;
          w_next    = RD_IDLE;
        end
      end
      default:   w_next = RD_IDLE;
    endcase
  end

  assign o_arvalid = (r_state == RD_AR);
  assign o_araddr  = r_addr;
  assign o_arsize  = r_size;
  assign o_state   = r_state;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-like inst/data ports onto one single-beat AXI4 master.
// Optional BRIDGE_RAW_ADDR_CHECK_EN: stall data reads only on a same-word pending write.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] INST_ID = AXI_INST_ID,
  parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_inst_req,
  input  logic [ADDR_W-1:0]   i_inst_addr,
  output logic                o_inst_addr_ok,
  output logic                o_inst_data_ok,
  output logic [DATA_W-1:0]   o_inst_rdata,
  input  logic                i_data_req,
  input  logic                i_data_wr,
  input  logic [1:0]          i_data_size,
  input  logic [DATA_W/8-1:0] i_data_wstrb,
  input  logic [ADDR_W-1:0]   i_data_addr,
  input  logic [DATA_W-1:0]   i_data_wdata,
  output logic                o_data_addr_ok,
  output logic                o_data_data_ok,
  output logic [DATA_W-1:0]   o_data_rdata,
  output logic [3:0]          o_arid,
  output logic [ADDR_W-1:0]   o_araddr,
  output logic [2:0]          o_arsize,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [3:0]          i_rid,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic                i_rvalid,
  output logic                o_rready,
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic [2:0]          o_awsize,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic                i_bvalid,
  output logic                o_bready,
  output rd_state_e           o_dbg_inst_state,
  output rd_state_e           o_dbg_data_state,
  output wr_state_e           o_dbg_wr_state
);

  // Handshakes: a transfer happens on any posedge where valid && ready; once raised,
  // valid and its payload hold until that edge. Core side: req holds until addr_ok.
  logic              w_inst_arvalid, w_data_arvalid, w_ar_busy;
  logic [ADDR_W-1:0] w_inst_araddr, w_data_araddr;
  logic [2:0]        w_inst_arsize, w_data_arsize;
  logic              w_inst_rd_ok, w_data_rd_ok, w_store_ok;
  logic              w_inst_rd_dok, w_data_rd_dok;
  logic              w_raw_block;
  rd_state_e         w_inst_state, w_data_state;

  wr_state_e           r_wr_state, w_wr_next;
  logic                r_awvalid, w_awvalid_next;
  logic                r_wvalid, w_wvalid_next;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [2:0]          r_awsize;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;

  assign w_ar_busy = w_inst_arvalid | w_data_arvalid;

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
  assign w_raw_block = (r_wr_state != WR_IDLE) &&
                       (r_awaddr[ADDR_W-1:2] == i_data_addr[ADDR_W-1:2]);
`else
  assign w_raw_block = (r_wr_state != WR_IDLE);
`endif

  // Data reads take priority for the shared AR channel; inst only gets it otherwise.
  assign w_data_rd_ok = i_data_req && !i_data_wr && (w_data_state == RD_IDLE) &&
                        !w_ar_busy && !w_raw_block;
  assign w_inst_rd_ok = i_inst_req && (w_inst_state == RD_IDLE) && !w_ar_busy &&
                        !w_data_rd_ok;
  assign w_store_ok   = i_data_req && i_data_wr && (r_wr_state == WR_IDLE) &&
                        (w_data_state == RD_IDLE);

  sram_axi_bridge_rd_fsm #(.ADDR_W(ADDR_W), .ID(INST_ID)) u_inst_rd (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_inst_rd_ok),
    .i_addr    (i_inst_addr),
    .i_size    (axi_size(SIZE_W)),
    .i_arready (i_arready && !w_data_arvalid),
    .i_rvalid  (i_rvalid),
    .i_rid     (i_rid),
    .o_arvalid (w_inst_arvalid),
    .o_araddr  (w_inst_araddr),
    .o_arsize  (w_inst_arsize),
    .o_data_ok (w_inst_rd_dok),
    .o_state   (w_inst_state)
  );

  sram_axi_bridge_rd_fsm #(.ADDR_W(ADDR_W), .ID(DATA_ID)) u_data_rd (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_data_rd_ok),
    .i_addr    (i_data_addr),
    .i_size    (axi_size(i_data_size)),
    .i_arready (i_arready),
    .i_rvalid  (i_rvalid),
    .i_rid     (i_rid),
    .o_arvalid (w_data_arvalid),
    .o_araddr  (w_data_araddr),
    .o_arsize  (w_data_arsize),
    .o_data_ok (w_data_rd_dok),
    .o_state   (w_data_state)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_state <= WR_IDLE;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_awaddr   <= '0;
      r_awsize   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      r_awvalid  <= w_awvalid_next;
      r_wvalid   <= w_wvalid_next;
      if (w_store_ok) begin
        r_awaddr <= i_data_addr;
        r_awsize <= axi_size(i_data_size);
        r_wdata  <= i_data_wdata;
        r_wstrb  <= i_data_wstrb;
      end
    end
  end

  // AW and W are raised together but may complete on different cycles.
  always_comb begin
    w_wr_next      = r_wr_state;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_store_ok) begin
          w_wr_next      = WR_AWW;
          w_awvalid_next = 1'b1;
          w_wvalid_next  = 1'b1;
        end
      end
      WR_AWW: begin
        w_awvalid_next = r_awvalid && !i_awready;
        w_wvalid_next  = r_wvalid && !i_wready;
        if (!w_awvalid_next && !w_wvalid_next) w_wr_next = WR_WAIT_B;
      end
      WR_WAIT_B: if (i_bvalid) w_wr_next = WR_IDLE;
      default:   w_wr_next = WR_IDLE;
    endcase
  end

  assign o_arvalid = w_ar_busy;
  assign o_arid    = w_data_arvalid ? DATA_ID : INST_ID;
  assign o_araddr  = w_data_arvalid ? w_data_araddr : w_inst_araddr;
  assign o_arsize  = w_data_arvalid ? w_data_arsize : w_inst_arsize;
  assign o_rready  = 1'b1;
  assign o_bready  = 1'b1;

  assign o_awvalid = r_awvalid;
  assign o_awaddr  = r_awaddr;
  assign o_awsize  = r_awsize;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;

  assign o_inst_addr_ok = w_inst_rd_ok;
  assign o_inst_data_ok = w_inst_rd_dok;
  assign o_inst_rdata   = i_rdata;
  assign o_data_addr_ok = w_data_rd_ok | w_store_ok;
  assign o_data_data_ok = w_data_rd_dok | ((r_wr_state == WR_WAIT_B) && i_bvalid);
  assign o_data_rdata   = i_rdata;

  assign o_dbg_inst_state = w_inst_state;
  assign o_dbg_data_state = w_data_state;
  assign o_dbg_wr_state   = r_wr_state;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge; honours BRIDGE_RAW_ADDR_CHECK_EN.
module tb_sram_axi_bridge;
  import sram_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  rd_state_e   dbg_inst_state, dbg_data_state;
  wr_state_e   dbg_wr_state;

  int n_checks = 0;
  int n_errors = 0;
  int aw_cnt = 0;
  int w_cnt = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .i_clk(clk), .i_reset(reset),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr),
    .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
    .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size),
    .i_data_wstrb(data_wstrb), .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
    .o_arid(arid), .o_araddr(araddr), .o_arsize(arsize), .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rvalid(rvalid), .o_rready(rready),
    .o_awaddr(awaddr), .o_awsize(awsize), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
    .i_bvalid(bvalid), .o_bready(bready),
    .o_dbg_inst_state(dbg_inst_state), .o_dbg_data_state(dbg_data_state),
    .o_dbg_wr_state(dbg_wr_state)
  );

  always @(posedge clk) begin
    if (!reset && awvalid && awready) aw_cnt++;
    if (!reset && wvalid && wready) w_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic ar_handshake(input logic [3:0] e_id, input logic [31:0] e_addr,
                              input logic [2:0] e_size);
    int n = 0;
    while (!arvalid && n < 20) begin
      step();
      n++;
    end
    check("ar_seen", {31'd0, arvalid}, 32'd1);
    check("arid", {28'd0, arid}, {28'd0, e_id});
    check("araddr", araddr, e_addr);
    check("arsize", {29'd0, arsize}, {29'd0, e_size});
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1 check("ar_drop", {31'd0, arvalid}, 32'd0);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d,
                        input logic e_inst, input logic e_data);
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    #1;
    check("r_inst_ok", {31'd0, inst_data_ok}, {31'd0, e_inst});
    check("r_data_ok", {31'd0, data_data_ok}, {31'd0, e_data});
    if (e_inst) check("inst_rdata", inst_rdata, d);
    if (e_data) check("data_rdata", data_rdata, d);
    step();
    rvalid = 1'b0;
  endtask

  task automatic aw_w_handshake(input logic [31:0] e_addr, input logic [2:0] e_size,
                                input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
    int n = 0;
    while (!awvalid && n < 20) begin
      step();
      n++;
    end
    check("aw_seen", {31'd0, awvalid}, 32'd1);
    check("w_seen", {31'd0, wvalid}, 32'd1);
    check("awaddr", awaddr, e_addr);
    check("awsize", {29'd0, awsize}, {29'd0, e_size});
    check("wdata", wdata, e_wdata);
    check("wstrb", {28'd0, wstrb}, {28'd0, e_wstrb});
    awready = 1'b1;
    wready  = 1'b1;
    step();
    awready = 1'b0;
    wready  = 1'b0;
    #1;
    check("aw_drop", {31'd0, awvalid}, 32'd0);
    check("w_drop", {31'd0, wvalid}, 32'd0);
  endtask

  task automatic b_beat();
    bvalid = 1'b1;
    #1 check("b_data_ok", {31'd0, data_data_ok}, 32'd1);
    step();
    bvalid = 1'b0;
    #1 check("b_data_ok_end", {31'd0, data_data_ok}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_wstrb = 0; data_addr = 0; data_wdata = 0; arready = 0; rid = 0; rdata = 0;
    rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    repeat (3) @(posedge clk);
    step();
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check("rst_wvalid", {31'd0, wvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd1);
    check("rst_bready", {31'd0, bready}, 32'd1);
    check("rst_wr_state", {30'd0, dbg_wr_state}, {30'd0, WR_IDLE});
    reset = 1'b0;
    step();

    // Instruction fetch, arready held off for 2 cycles.
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    #1 check("t1_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    step();
    check("t1_addr_ok_once", {31'd0, inst_addr_ok}, 32'd0);
    inst_req = 1'b0;
    check("t1_arvalid_w1", {31'd0, arvalid}, 32'd1);
    step();
    check("t1_arvalid_w2", {31'd0, arvalid}, 32'd1);
    ar_handshake(4'd0, 32'h1c00_0000, 3'd2);
    r_beat(4'd0, 32'h0280_0406, 1'b1, 1'b0);

    // Simultaneous inst and data reads; data wins AR, responses return out of order.
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0200;
    #1;
    check("t2_data_ok_first", {31'd0, data_addr_ok}, 32'd1);
    check("t2_inst_blocked", {31'd0, inst_addr_ok}, 32'd0);
    step();
    data_req = 1'b0;
    #1 check("t2_inst_wait_ar", {31'd0, inst_addr_ok}, 32'd0);
    ar_handshake(4'd1, 32'h0000_0200, 3'd2);
    check("t2_inst_granted", {31'd0, inst_addr_ok}, 32'd1);
    step();
    inst_req = 1'b0;
    ar_handshake(4'd0, 32'h0000_0100, 3'd2);
    r_beat(4'd0, 32'haaaa_0000, 1'b1, 1'b0);
    r_beat(4'd1, 32'hbbbb_1111, 1'b0, 1'b1);
    r_beat(4'd5, 32'h1234_5678, 1'b0, 1'b0);

    // Word store, awready ahead of wready.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_1000;
    data_wstrb = 4'hf; data_wdata = 32'hdead_beef;
    #1 check("t3_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0; data_wr = 1'b0;
    check("t3_awaddr", awaddr, 32'h0000_1000);
    check("t3_awsize", {29'd0, awsize}, 32'd2);
    check("t3_wdata", wdata, 32'hdead_beef);
    check("t3_wstrb", {28'd0, wstrb}, 32'hf);
    awready = 1'b1;
    step();
    awready = 1'b0;
    #1;
    check("t3_aw_drop", {31'd0, awvalid}, 32'd0);
    check("t3_w_hold", {31'd0, wvalid}, 32'd1);
    wready = 1'b1;
    step();
    wready = 1'b0;
    #1;
    check("t3_w_drop", {31'd0, wvalid}, 32'd0);
    check("t3_aw_count", aw_cnt, 32'd1);
    check("t3_w_count", w_cnt, 32'd1);
    check("t3_no_early_ok", {31'd0, data_data_ok}, 32'd0);

    // Load from the pending store's word stalls until the store completes.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
    #1 check("t4_raw_stall0", {31'd0, data_addr_ok}, 32'd0);
    step();
    check("t4_raw_stall1", {31'd0, data_addr_ok}, 32'd0);
    bvalid = 1'b1;
    #1;
    check("t4_store_done", {31'd0, data_data_ok}, 32'd1);
    check("t4_raw_stall2", {31'd0, data_addr_ok}, 32'd0);
    step();
    bvalid = 1'b0;
    #1 check("t4_load_accept", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0;
    ar_handshake(4'd1, 32'h0000_1000, 3'd2);
    r_beat(4'd1, 32'hcafe_f00d, 1'b0, 1'b1);

    // Byte store, then a load to a different word while the store is pending.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_1003;
    data_wstrb = 4'h8; data_wdata = 32'h1100_0000;
    #1 check("t5_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    check("t5_awsize", {29'd0, awsize}, 32'd0);
    check("t5_awaddr", awaddr, 32'h0000_1003);
    check("t5_wstrb", {28'd0, wstrb}, 32'h8);
    data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_2000;
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    #1 check("t5_load_early", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0;
    ar_handshake(4'd1, 32'h0000_2000, 3'd2);
    aw_w_handshake(32'h0000_1003, 3'd0, 32'h1100_0000, 4'h8);
    r_beat(4'd1, 32'h5555_aaaa, 1'b0, 1'b1);
    b_beat();
`else
    #1 check("t5_load_stall", {31'd0, data_addr_ok}, 32'd0);
    aw_w_handshake(32'h0000_1003, 3'd0, 32'h1100_0000, 4'h8);
    check("t5_load_stall_b", {31'd0, data_addr_ok}, 32'd0);
    b_beat();
    check("t5_load_accept", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0;
    ar_handshake(4'd1, 32'h0000_2000, 3'd2);
    r_beat(4'd1, 32'h5555_aaaa, 1'b0, 1'b1);
`endif

    // Inst R and data B in the same cycle.
    inst_req = 1'b1; inst_addr = 32'h0000_0080;
    #1 check("t6_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
    step();
    inst_req = 1'b0;
    ar_handshake(4'd0, 32'h0000_0080, 3'd2);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h0000_3000;
    data_wstrb = 4'h3; data_wdata = 32'h0000_abcd;
    #1 check("t6_store_ok", {31'd0, data_addr_ok}, 32'd1);
    step();
    data_req = 1'b0; data_wr = 1'b0;
    aw_w_handshake(32'h0000_3000, 3'd1, 32'h0000_abcd, 4'h3);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0077; bvalid = 1'b1;
    #1;
    check("t6_inst_dok", {31'd0, inst_data_ok}, 32'd1);
    check("t6_data_dok", {31'd0, data_data_ok}, 32'd1);
    check("t6_inst_rdata", inst_rdata, 32'h0000_0077);
    step();
    rvalid = 1'b0; bvalid = 1'b0;

    // Reset while waiting on R: the stale beat must not complete anything.
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    #1 check("t7_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
    step();
    inst_req = 1'b0;
    ar_handshake(4'd0, 32'h0000_0040, 3'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hdead_0040;
    #1 check("t7_no_late_ok", {31'd0, inst_data_ok}, 32'd0);
    step();
    rvalid = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0044;
    #1 check("t7_next_ok", {31'd0, inst_addr_ok}, 32'd1);
    step();
    inst_req = 1'b0;
    ar_handshake(4'd0, 32'h0000_0044, 3'd2);
    r_beat(4'd0, 32'h4444_4444, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
